mem_arbiter: RTL

- Sole owner of the single off-chip SRAM port, shared by instruction fetch (IF, read only) and the MEM stage (read/write).
- Arbitrates between the two requesters, sequences the SRAM control pins through multi-cycle read/write timing, and returns done/data.
- Drives the stall signals that the PC, IF/ID and downstream pipeline registers (including MEM/WB keep) consume.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, owner codes,
// timer width and a helper that converts a cycle count into a timer preload.
package mem_arb_pkg;

  // Wide enough for the 1..7 cycle read/write pulse lengths.
  localparam int TIMER_W = 3;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_READ     = 3'd1,
    ARB_WR_SETUP = 3'd2,
    ARB_WR_PULSE = 3'd3,
    ARB_WR_HOLD  = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

  // A phase lasting n cycles ends on the edge where the timer reads zero,
  // so it is loaded with n-1 on entry.
  function automatic logic [TIMER_W-1:0] cycles_to_load(input int n);
    return TIMER_W'(n - 1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter with a zero flag; times both the read strobe and
// the write pulse of the SRAM arbiter.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch (read only) and the
// MEM stage (read/write). MEM has fixed priority. Every access is followed by
// a mandatory idle cycle (the cycle in which done is high) for bus turnaround.
// Optional build macro MEM_ARB_PERF_EN adds a saturating conflict counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int READ_CYCLES = 1,
  parameter int WE_CYCLES   = 1
) (
  input  logic              mai_clk,
  input  logic              mai_rst,
  input  logic              mai_if_req,
  input  logic [ADDR_W-1:0] mai_if_addr,
  input  logic              mai_mem_req,
  input  logic              mai_mem_wr,
  input  logic [ADDR_W-1:0] mai_mem_addr,
  input  logic [DATA_W-1:0] mai_mem_wdata,
  input  logic [DATA_W-1:0] mai_ram_din,
  output logic              mao_if_done,
  output logic              mao_mem_done,
  output logic [DATA_W-1:0] mao_rdata,
  output logic              mao_if_stall,
  output logic              mao_mem_stall,
  output logic [ADDR_W-1:0] mao_ram_addr,
  output logic [DATA_W-1:0] mao_ram_dout,
  output logic              mao_ram_dout_en,
  output logic              mao_ram_ce_n,
  output logic              mao_ram_oe_n,
  output logic              mao_ram_we_n
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       mao_conflict_cnt
`endif
);

  localparam logic [TIMER_W-1:0] READ_LOAD = cycles_to_load(READ_CYCLES);
  localparam logic [TIMER_W-1:0] WE_LOAD   = cycles_to_load(WE_CYCLES);

  arb_state_t  state_reg, state_next;
  arb_owner_t  owner_reg;

  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_dout_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              if_done_reg, mem_done_reg;
  logic              ce_n_reg, oe_n_reg, we_n_reg, dout_en_reg;

  logic              turnaround;
  logic              grant, grant_mem;
  logic              timer_load, timer_dec, timer_zero;
  logic [TIMER_W-1:0] timer_val;
  logic              capture;
  logic              if_done_next, mem_done_next;

  // A done pulse marks the idle cycle that must separate two accesses;
  // requests still asserted in that cycle are not re-arbitrated.
  assign turnaround = if_done_reg | mem_done_reg;

  mem_arb_timer #(.W(TIMER_W)) u_timer (
    .clk      (mai_clk),
    .srst     (mai_rst),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Next-state, arbitration and timer control.
  always_comb begin
    state_next    = state_reg;
    grant         = 1'b0;
    grant_mem     = 1'b0;
    timer_load    = 1'b0;
    timer_val     = '0;
    timer_dec     = 1'b0;
    capture       = 1'b0;
    if_done_next  = 1'b0;
    mem_done_next = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (!turnaround) begin
          if (mai_mem_req) begin
            grant     = 1'b1;
            grant_mem = 1'b1;
            if (mai_mem_wr) begin
              state_next = ARB_WR_SETUP;
            end else begin
              state_next = ARB_READ;
              timer_load = 1'b1;
              timer_val  = READ_LOAD;
            end
          end else if (mai_if_req) begin
            grant      = 1'b1;
            state_next = ARB_READ;
            timer_load = 1'b1;
            timer_val  = READ_LOAD;
          end
        end
      end
      ARB_READ: begin
        if (timer_zero) begin
          capture    = 1'b1;
          state_next = ARB_IDLE;
          if (owner_reg == OWN_IF) begin
            if_done_next = 1'b1;
          end else begin
            mem_done_next = 1'b1;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      ARB_WR_SETUP: begin
        state_next = ARB_WR_PULSE;
        timer_load = 1'b1;
        timer_val  = WE_LOAD;
      end
      ARB_WR_PULSE: begin
        if (timer_zero) begin
          state_next = ARB_WR_HOLD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ARB_WR_HOLD: begin
        mem_done_next = 1'b1;
        state_next    = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // State, owner, latched SRAM address/data, read data and done pulses.
  always_ff @(posedge mai_clk) begin
    if (mai_rst) begin
      state_reg    <= ARB_IDLE;
      owner_reg    <= OWN_IF;
      ram_addr_reg <= '0;
      ram_dout_reg <= '0;
      rdata_reg    <= '0;
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      if_done_reg  <= if_done_next;
      mem_done_reg <= mem_done_next;
      if (grant) begin
        owner_reg    <= grant_mem ? OWN_MEM : OWN_IF;
        ram_addr_reg <= grant_mem ? mai_mem_addr : mai_if_addr;
        if (grant_mem && mai_mem_wr) begin
          ram_dout_reg <= mai_mem_wdata;
        end
      end
      if (capture) begin
        rdata_reg <= mai_ram_din;
      end
    end
  end

  // Strobes are registered from the next state so the pins are glitch-free
  // and track the state register exactly.
  always_ff @(posedge mai_clk) begin
    if (mai_rst) begin
      ce_n_reg    <= 1'b1;
      oe_n_reg    <= 1'b1;
      we_n_reg    <= 1'b1;
      dout_en_reg <= 1'b0;
    end else begin
      ce_n_reg    <= (state_next == ARB_IDLE);
      oe_n_reg    <= (state_next != ARB_READ);
      we_n_reg    <= (state_next != ARB_WR_PULSE);
      dout_en_reg <= (state_next == ARB_WR_SETUP) ||
                     (state_next == ARB_WR_PULSE) ||
                     (state_next == ARB_WR_HOLD);
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt_reg;

  // Count arbitration edges at which both requesters compete; saturates.
  always_ff @(posedge mai_clk) begin
    if (mai_rst) begin
      conflict_cnt_reg <= '0;
    end else if ((state_reg == ARB_IDLE) && !turnaround && mai_if_req &&
                 mai_mem_req && (conflict_cnt_reg != 16'hFFFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
    end
  end

  assign mao_conflict_cnt = conflict_cnt_reg;
`endif

  assign mao_if_done     = if_done_reg;
  assign mao_mem_done    = mem_done_reg;
  assign mao_rdata       = rdata_reg;
  assign mao_if_stall    = mai_if_req & ~if_done_reg;
  assign mao_mem_stall   = mai_mem_req & ~mem_done_reg;
  assign mao_ram_addr    = ram_addr_reg;
  assign mao_ram_dout    = ram_dout_reg;
  assign mao_ram_dout_en = dout_en_reg;
  assign mao_ram_ce_n    = ce_n_reg;
  assign mao_ram_oe_n    = oe_n_reg;
  assign mao_ram_we_n    = we_n_reg;

endmodule
